pin_impact: RTL

Per-physics-step pin velocity generator: on each `start_in` it scans the ten pin positions against the ball and produces `pins_vx`, `pins_vy` and `pins_hit`, then pulses `valid_out`. It is the producer for the pin position integrator, whose `valid_in`, `pins_vx_in`, `pins_vy_in` and `pins_hit_in` connect directly to this block's `valid_out`, `pins_vx_out`, `pins_vy_out` and `pins_hit_out`. It also consumes the integrator's `pins_x`/`pins_y` as its position inputs. Pin-to-pin collisions are out of scope.

---
 rtl/pin_impact.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/pin_impact.sv
// Per-physics-step pin velocity generator: scans ten pins against the ball
// through a two-stage pipeline and publishes velocities and sticky hit flags.
module pin_impact #(
    parameter int PIN_RADIUS    = 16,
    parameter int BALL_RADIUS   = 24,
    parameter int KICK          = 8,
    parameter int FRICTION      = 1,
    parameter int SCREEN_WIDTH  = 1024,
    parameter int SCREEN_HEIGHT = 768
) (
    input  logic                clk_in,
    input  logic                rst_n_in,
    input  logic                start_in,
    input  logic [10:0]         ball_x_in,
    input  logic [9:0]          ball_y_in,
    input  logic [15:0]         ball_vx_in,
    input  logic [15:0]         ball_vy_in,
    input  logic [9:0][10:0]    pins_x_in,
    input  logic [9:0][9:0]     pins_y_in,
    output logic [9:0][15:0]    pins_vx_out,
    output logic [9:0][15:0]    pins_vy_out,
    output logic [9:0]          pins_hit_out,
    output logic                valid_out,
    output logic                busy_out
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    localparam logic [23:0]        HIT_LIM = 24'((PIN_RADIUS + BALL_RADIUS) * (PIN_RADIUS + BALL_RADIUS));
    localparam logic signed [16:0] KICK17  = 17'(KICK);
    localparam logic signed [16:0] SAT_HI  = 17'sd32767;
    localparam logic signed [16:0] SAT_LO  = -17'sd32768;
    localparam logic signed [15:0] FRIC16  = 16'(FRICTION);

    state_t state, state_nx;
    logic        scan, done;
    logic [3:0]  idx;

    logic [10:0]        ball_x;
    logic [9:0]         ball_y;
    logic signed [15:0] ball_vx, ball_vy;
    logic [9:0][10:0]   pin_x;
    logic [9:0][9:0]    pin_y;

    logic signed [11:0] dx_p1, dy_p1;
    logic               off_p1;
    logic [3:0]         idx_p1;
    logic               vld_p1;

    logic [9:0][15:0]   vx_w, vy_w;
    logic [9:0]         hit_w;

    logic signed [23:0] dx2, dy2;
    logic [23:0]        d2;
    logic               collide;
    logic signed [15:0] cur_vx, cur_vy, new_vx, new_vy;
    logic               new_hit;

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        if (v > SAT_HI)
            return 16'sh7FFF;
        else if (v < SAT_LO)
            return 16'sh8000;
        else
            return v[15:0];
    endfunction

    function automatic logic signed [15:0] kick(input logic signed [15:0] v, input logic neg);
        logic signed [16:0] sum;
        sum = 17'(v) + (neg ? -KICK17 : KICK17);
        return sat16(sum);
    endfunction

    function automatic logic signed [15:0] decay(input logic signed [15:0] v);
        if (v <= FRIC16 && v >= -FRIC16)
            return 16'sd0;
        else if (v > 16'sd0)
            return v - FRIC16;
        else
            return v + FRIC16;
    endfunction

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start_in) state_nx = SCAN;
            SCAN:    if (idx == 4'd9) state_nx = DRAIN;
            DRAIN:   state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        busy_out = (state != IDLE);
        scan     = (state == SCAN);
        done     = (state == DONE);
    end

    // snapshot of ball and pins, taken on the accepted start
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            idx     <= '0;
            ball_x  <= '0;
            ball_y  <= '0;
            ball_vx <= '0;
            ball_vy <= '0;
            pin_x   <= '0;
            pin_y   <= '0;
        end else if (state == IDLE && start_in) begin
            idx     <= '0;
            ball_x  <= ball_x_in;
            ball_y  <= ball_y_in;
            ball_vx <= ball_vx_in;
            ball_vy <= ball_vy_in;
            pin_x   <= pins_x_in;
            pin_y   <= pins_y_in;
        end else if (scan) begin
            idx <= idx + 4'd1;
        end
    end

    // stage 1: offsets and off-screen flag
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            dx_p1  <= '0;
            dy_p1  <= '0;
            off_p1 <= 1'b0;
            idx_p1 <= '0;
            vld_p1 <= 1'b0;
        end else begin
            vld_p1 <= scan;
            if (scan) begin
                dx_p1  <= $signed({1'b0, pin_x[idx]}) - $signed({1'b0, ball_x});
                dy_p1  <= $signed({2'b0, pin_y[idx]}) - $signed({2'b0, ball_y});
                off_p1 <= (32'(pin_x[idx]) >= SCREEN_WIDTH) || (32'(pin_y[idx]) >= SCREEN_HEIGHT);
                idx_p1 <= idx;
            end
        end
    end

    // stage 2: distance test and velocity update
    always_comb begin
        dx2     = 24'(dx_p1) * 24'(dx_p1);
        dy2     = 24'(dy_p1) * 24'(dy_p1);
        d2      = $unsigned(dx2) + $unsigned(dy2);
        collide = !off_p1 && (d2 < HIT_LIM);
        cur_vx  = $signed(vx_w[idx_p1]);
        cur_vy  = $signed(vy_w[idx_p1]);
        new_hit = hit_w[idx_p1];
        new_vx  = '0;
        new_vy  = '0;
        if (hit_w[idx_p1]) begin
            new_vx = decay(cur_vx);
            new_vy = decay(cur_vy);
        end else if (collide) begin
            new_hit = 1'b1;
            new_vx  = kick(ball_vx, dx_p1[11]);
            new_vy  = kick(ball_vy, dy_p1[11]);
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            vx_w  <= '0;
            vy_w  <= '0;
            hit_w <= '0;
        end else if (vld_p1) begin
            vx_w[idx_p1]  <= new_vx;
            vy_w[idx_p1]  <= new_vy;
            hit_w[idx_p1] <= new_hit;
        end
    end

    // publish stage: outputs change only alongside valid_out
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pins_vx_out  <= '0;
            pins_vy_out  <= '0;
            pins_hit_out <= '0;
            valid_out    <= 1'b0;
        end else begin
            valid_out <= done;
            if (done) begin
                pins_vx_out  <= vx_w;
                pins_vy_out  <= vy_w;
                pins_hit_out <= hit_w;
            end
        end
    end

endmodule
